// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch path. Holds the current fetch
// address, updates it once per cycle from PC_OP, and keeps a small
// hardware return-address stack for CALL/RET. OVERFLOW and UNDERFLOW are
// sticky error flags.
module pc_sequencer #(
    parameter int unsigned       ADDR_W      = 19,
    parameter int unsigned       OFF_W       = 8,
    parameter int unsigned       STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              STALL,
    input  logic [2:0]        PC_OP,
    input  logic              COND,
    input  logic [ADDR_W-1:0] IN_ADDRESS,
    input  logic [OFF_W-1:0]  OFFSET,
    input  logic              ERR_CLR,
    output logic [ADDR_W-1:0] PC_OUT,
    output logic              STACK_EMPTY,
    output logic              STACK_FULL,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);

    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_HOLD   = 3'b000,
        OP_INC    = 3'b001,
        OP_CLEAR  = 3'b010,
        OP_JUMP   = 3'b011,
        OP_BRANCH = 3'b100,
        OP_CALL   = 3'b101,
        OP_RET    = 3'b110,
        OP_RSVD   = 3'b111
    } pc_op_e;

    pc_op_e            op;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] off_ext;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;
    logic              push_en;
    logic              ovf_set;
    logic              unf_set;
    logic              full;
    logic              empty;

    // Next PC, stack count and error flags from the current command.
    always_comb begin
        op       = pc_op_e'(PC_OP);
        pc_inc   = pc_q + ADDR_W'(1);
        off_ext  = ADDR_W'($signed(OFFSET));
        full     = (cnt_q == CNT_W'(STACK_DEPTH));
        empty    = (cnt_q == '0);
        push_idx = IDX_W'(cnt_q);
        top_idx  = IDX_W'(cnt_q - CNT_W'(1));

        pc_d     = pc_q;
        cnt_d    = cnt_q;
        push_en  = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;

        // A stalled cycle freezes everything except the ERR_CLR path below.
        if (!STALL) begin
            unique case (op)
                OP_INC:    pc_d = pc_inc;
                OP_CLEAR:  pc_d = '0;
                OP_JUMP:   pc_d = IN_ADDRESS;
                OP_BRANCH: pc_d = COND ? (pc_q + off_ext) : pc_inc;
                OP_CALL: begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        pc_d    = IN_ADDRESS;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else begin
                        pc_d  = stack_q[top_idx];
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: pc_d = pc_q;
            endcase
        end

        // A new error in the same cycle as ERR_CLR wins.
        ovf_d = ovf_set | (ovf_q & ~ERR_CLR);
        unf_d = unf_set | (unf_q & ~ERR_CLR);
    end

    // PC, stack count and sticky flags.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q  <= RESET_VEC;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Return-address storage; contents are meaningless while count is zero,
    // so no reset is needed.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign PC_OUT      = pc_q;
    assign STACK_EMPTY = (cnt_q == '0);
    assign STACK_FULL  = (cnt_q == CNT_W'(STACK_DEPTH));
    assign OVERFLOW    = ovf_q;
    assign UNDERFLOW   = unf_q;

endmodule
